// File: rtl/controlador_busca_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pacote_busca
// Description : Shared constants, state encoding and helpers for the
//               controlador_busca instruction-fetch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pacote_busca;

   localparam int C_ADDR_W     = 8;
   localparam int C_DATA_W     = 8;
   localparam int C_RESET_PC   = 0;
   localparam int C_STARVE_LIM = 4;

   localparam logic [0:0] C_ST_FETCH  = 1'b0;
   localparam logic [0:0] C_ST_HALTED = 1'b1;

   // Counter width able to hold 0..lim-1, never narrower than one bit.
   function automatic int cnt_width(input int lim);
      return (lim > 1) ? $clog2(lim) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/controlador_busca_if.sv
`default_nettype none
// ============================================================================
// Module      : controlador_busca_if
// Description : ROM, decode-side and debug signals of the fetch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface controlador_busca_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic [DATA_W-1:0] inst_out;
   logic [ADDR_W-1:0] inst_pc;
   logic              inst_valid;
   logic              inst_ready;
   logic              jump_en;
   logic [ADDR_W-1:0] jump_addr;
   logic              halt;
   logic              dbg_req;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_data;
   logic              dbg_ack;
   logic              halted;

   modport master (
      output rom_addr,
      input  rom_data,
      output inst_out, inst_pc, inst_valid,
      input  inst_ready,
      input  jump_en, jump_addr, halt,
      input  dbg_req, dbg_addr,
      output dbg_data, dbg_ack,
      output halted
   );

   modport slave (
      input  rom_addr,
      output rom_data,
      input  inst_out, inst_pc, inst_valid,
      output inst_ready,
      output jump_en, jump_addr, halt,
      output dbg_req, dbg_addr,
      input  dbg_data, dbg_ack,
      input  halted
   );
endinterface
`default_nettype wire

// File: rtl/controlador_busca_arbitro_rom.sv
`default_nettype none
// ============================================================================
// Module      : arbitro_rom
// Description : ROM address mux between core fetch and debug reads, with a
//               starvation counter that forces a debug grant.
// Revision    : 1.0 - initial release
// ============================================================================
module arbitro_rom
   import pacote_busca::*;
#(
   parameter int ADDR_W     = C_ADDR_W,
   parameter int DATA_W     = C_DATA_W,
   parameter int STARVE_LIM = C_STARVE_LIM
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] pc,
   input  logic              port_free,
   input  logic              dbg_req,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              grant,
   output logic [DATA_W-1:0] dbg_data,
   output logic              dbg_ack
);

   localparam int c_cnt_w = cnt_width(STARVE_LIM);
   localparam logic [c_cnt_w-1:0] c_lim = c_cnt_w'(STARVE_LIM - 1);

   logic [c_cnt_w-1:0] r_starve_cnt;
   logic [DATA_W-1:0]  r_dbg_data;
   logic               r_dbg_ack;
   logic               w_pending;
   logic               w_starved;
   logic               w_grant;

   // The ack cycle is excluded so a request still held there is not served twice.
   assign w_pending = dbg_req & ~r_dbg_ack;
   assign w_starved = (r_starve_cnt == c_lim);
   assign w_grant   = w_pending & (port_free | w_starved);

   assign rom_addr = w_grant ? dbg_addr : pc;
   assign grant    = w_grant;
   assign dbg_data = r_dbg_data;
   assign dbg_ack  = r_dbg_ack;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_starve_cnt <= '0;
         r_dbg_data   <= '0;
         r_dbg_ack    <= 1'b0;
      end else if (w_grant) begin
         r_dbg_data   <= rom_data;
         r_dbg_ack    <= 1'b1;
         r_starve_cnt <= '0;
      end else begin
         r_dbg_ack <= 1'b0;
         if (w_pending)
            r_starve_cnt <= r_starve_cnt + c_cnt_w'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/controlador_busca.sv
`default_nettype none
// ============================================================================
// Module      : controlador_busca
// Description : Instruction-fetch sequencer: PC, valid/ready output stage,
//               jump/halt handling. Optional macro CONTROLADOR_BUSCA_PERF_EN
//               adds saturating fetch/stall performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module controlador_busca
   import pacote_busca::*;
#(
   parameter int ADDR_W     = C_ADDR_W,
   parameter int DATA_W     = C_DATA_W,
   parameter int RESET_PC   = C_RESET_PC,
   parameter int STARVE_LIM = C_STARVE_LIM
) (
   input  logic                clk,
   input  logic                rst_n,
   controlador_busca_if.master bus
`ifdef CONTROLADOR_BUSCA_PERF_EN
   ,
   output logic [15:0]         perf_fetch,
   output logic [15:0]         perf_stall
`endif
);

   logic [0:0]        r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [DATA_W-1:0] r_inst_out;
   logic [ADDR_W-1:0] r_inst_pc;
   logic              r_inst_valid;

   logic w_out_free;
   logic w_accept;
   logic w_port_free;
   logic w_grant;
   logic w_fetch;

   assign w_out_free  = ~r_inst_valid | bus.inst_ready;
   assign w_accept    = r_inst_valid & bus.inst_ready;
   assign w_port_free = (r_state == C_ST_HALTED) | (r_inst_valid & ~bus.inst_ready) | bus.halt;
   assign w_fetch     = (r_state == C_ST_FETCH) & w_out_free & ~bus.jump_en & ~w_grant & ~bus.halt;

   arbitro_rom #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .STARVE_LIM (STARVE_LIM)
   ) u_arbitro (
      .clk       (clk),
      .rst_n     (rst_n),
      .pc        (r_pc),
      .port_free (w_port_free),
      .dbg_req   (bus.dbg_req),
      .dbg_addr  (bus.dbg_addr),
      .rom_data  (bus.rom_data),
      .rom_addr  (bus.rom_addr),
      .grant     (w_grant),
      .dbg_data  (bus.dbg_data),
      .dbg_ack   (bus.dbg_ack)
   );

   assign bus.inst_out   = r_inst_out;
   assign bus.inst_pc    = r_inst_pc;
   assign bus.inst_valid = r_inst_valid;
   assign bus.halted     = (r_state == C_ST_HALTED);

   // A jump discards whatever sits in the output stage, even if accepted now.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc         <= ADDR_W'(RESET_PC);
         r_inst_out   <= '0;
         r_inst_pc    <= '0;
         r_inst_valid <= 1'b0;
      end else if (bus.jump_en) begin
         r_pc         <= bus.jump_addr;
         r_inst_valid <= 1'b0;
      end else if (w_fetch) begin
         r_inst_out   <= bus.rom_data;
         r_inst_pc    <= r_pc;
         r_inst_valid <= 1'b1;
         r_pc         <= r_pc + ADDR_W'(1);
      end else if (w_accept) begin
         r_inst_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= C_ST_FETCH;
      end else begin
         case (r_state)
            C_ST_FETCH:  if (bus.halt && w_out_free) r_state <= C_ST_HALTED;
            C_ST_HALTED: if (!bus.halt) r_state <= C_ST_FETCH;
            default:     r_state <= C_ST_FETCH;
         endcase
      end
   end

`ifdef CONTROLADOR_BUSCA_PERF_EN
   logic [15:0] r_perf_fetch;
   logic [15:0] r_perf_stall;
   logic        w_stall;

   assign w_stall    = (r_state == C_ST_FETCH) & ~w_fetch;
   assign perf_fetch = r_perf_fetch;
   assign perf_stall = r_perf_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_fetch <= '0;
         r_perf_stall <= '0;
      end else begin
         if (w_fetch && (r_perf_fetch != 16'hFFFF))
            r_perf_fetch <= r_perf_fetch + 16'd1;
         if (w_stall && (r_perf_stall != 16'hFFFF))
            r_perf_stall <= r_perf_stall + 16'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_controlador_busca.sv
`default_nettype none
// ============================================================================
// Module      : tb_controlador_busca
// Description : Directed scoreboard bench for controlador_busca with a
//               256x8 ROM holding ROM[i] = i ^ 0xA5.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controlador_busca;

   logic clk;
   logic rst_n;
   int   n_vec = 0;
   int   n_err = 0;

   logic [15:0] q_inst[$];
   logic [7:0]  q_dbg[$];

   controlador_busca_if #(.ADDR_W(8), .DATA_W(8)) bus ();

`ifdef CONTROLADOR_BUSCA_PERF_EN
   logic [15:0] perf_fetch;
   logic [15:0] perf_stall;
`endif

   controlador_busca dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus)
`ifdef CONTROLADOR_BUSCA_PERF_EN
      ,
      .perf_fetch (perf_fetch),
      .perf_stall (perf_stall)
`endif
   );

   assign bus.rom_data = bus.rom_addr ^ 8'hA5;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_range(input int start, input int count);
      for (int i = 0; i < count; i++) begin
         logic [7:0] a;
         a = 8'((start + i) % 256);
         q_inst.push_back({a, a ^ 8'hA5});
      end
   endtask

   // Scoreboard: every accepted instruction and every debug ack is popped and compared.
   always @(negedge clk) begin
      if (rst_n && bus.inst_valid && bus.inst_ready && !bus.jump_en) begin
         n_vec++;
         assert (q_inst.size() != 0) else begin
            n_err++;
            $error("FAIL inst_extra: got pc 0x%0h want no transfer", bus.inst_pc);
         end
         if (q_inst.size() != 0)
            chk("inst_pc_data", {16'h0, bus.inst_pc, bus.inst_out}, {16'h0, q_inst.pop_front()});
      end
      if (rst_n && bus.dbg_ack) begin
         n_vec++;
         assert (q_dbg.size() != 0) else begin
            n_err++;
            $error("FAIL dbg_extra: got data 0x%0h want no ack", bus.dbg_data);
         end
         if (q_dbg.size() != 0)
            chk("dbg_data", {24'h0, bus.dbg_data}, {24'h0, q_dbg.pop_front()});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "bench timeout");
   end

   initial begin
      int got;
      rst_n          = 1'b0;
      bus.inst_ready = 1'b0;
      bus.jump_en    = 1'b0;
      bus.jump_addr  = 8'h00;
      bus.halt       = 1'b0;
      bus.dbg_req    = 1'b0;
      bus.dbg_addr   = 8'h00;
      tick(); tick();
      @(negedge clk);
      chk("rst_valid",  {31'h0, bus.inst_valid}, 32'h0);
      chk("rst_out",    {24'h0, bus.inst_out}, 32'h0);
      chk("rst_pc",     {24'h0, bus.inst_pc}, 32'h0);
      chk("rst_ack",    {31'h0, bus.dbg_ack}, 32'h0);
      chk("rst_halted", {31'h0, bus.halted}, 32'h0);
      chk("rst_addr",   {24'h0, bus.rom_addr}, 32'h0);

      // Streaming with a 3-cycle hold at pc 5, then through the 0xFF wrap.
      tick();
      rst_n = 1'b1;
      bus.inst_ready = 1'b1;
      expect_range(0, 272);
      repeat (6) tick();
      bus.inst_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold_valid", {31'h0, bus.inst_valid}, 32'h1);
         chk("hold_pc",    {24'h0, bus.inst_pc}, 32'h05);
         chk("hold_out",   {24'h0, bus.inst_out}, 32'hA0);
         tick();
      end
      bus.inst_ready = 1'b1;
      repeat (267) tick();

      // Jump to 0x40 while 0x10 is held.
      bus.inst_ready = 1'b0;
      @(negedge clk);
      chk("prejump_pc", {24'h0, bus.inst_pc}, 32'h10);
      chk("stream_drained", q_inst.size(), 32'h0);
      tick();
      bus.jump_en = 1'b1;
      bus.jump_addr = 8'h40;
      bus.inst_ready = 1'b1;
      tick();
      bus.jump_en = 1'b0;
      @(negedge clk);
      chk("jump_bubble", {31'h0, bus.inst_valid}, 32'h0);
      tick();
      expect_range(8'h40, 4);
      @(negedge clk);
      chk("jump_first_valid", {31'h0, bus.inst_valid}, 32'h1);
      chk("jump_first_pc", {24'h0, bus.inst_pc}, 32'h40);
      tick(); tick(); tick();

      // Halt while 0x43 is held, debug read during HALTED, then resume.
      bus.halt = 1'b1;
      bus.inst_ready = 1'b0;
      @(negedge clk);
      chk("halt_held", {23'h0, bus.halted, bus.inst_pc}, {23'h0, 1'b0, 8'h43});
      tick();
      bus.inst_ready = 1'b1;
      tick();
      @(negedge clk);
      chk("halted_on", {30'h0, bus.halted, bus.inst_valid}, 32'h2);
      tick();
      bus.dbg_req = 1'b1;
      bus.dbg_addr = 8'h33;
      q_dbg.push_back(8'h96);
      @(negedge clk);
      chk("dbg_halt_addr", {24'h0, bus.rom_addr}, 32'h33);
      tick();
      bus.dbg_req = 1'b0;
      @(negedge clk);
      chk("dbg_halt_ack", {31'h0, bus.dbg_ack}, 32'h1);
      tick();
      bus.halt = 1'b0;
      @(negedge clk);
      chk("halted_stay", {31'h0, bus.halted}, 32'h1);
      tick();
      @(negedge clk);
      chk("resume_state", {30'h0, bus.halted, bus.inst_valid}, 32'h0);
      chk("resume_addr", {24'h0, bus.rom_addr}, 32'h44);
      expect_range(8'h44, 7);
      tick();
      @(negedge clk);
      chk("resume_pc", {23'h0, bus.inst_valid, bus.inst_pc}, {23'h0, 1'b1, 8'h44});
      tick();

      // Debug request while streaming: forced grant on the 4th request cycle.
      bus.dbg_req = 1'b1;
      bus.dbg_addr = 8'h80;
      q_dbg.push_back(8'h25);
      got = 0;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (n == 4) chk("starve_grant_addr", {24'h0, bus.rom_addr}, 32'h80);
         if (bus.dbg_ack) begin
            got = n;
            break;
         end
         tick();
      end
      chk("starve_ack_cycle", got, 32'd5);
      chk("starve_bubble", {31'h0, bus.inst_valid}, 32'h0);
      tick();
      bus.dbg_req = 1'b0;
      @(negedge clk);
      chk("ack_single", {31'h0, bus.dbg_ack}, 32'h0);
      chk("after_bubble", {23'h0, bus.inst_valid, bus.inst_pc}, {23'h0, 1'b1, 8'h49});
      tick();

      // Reset pulse in the middle of a pending debug request.
      bus.dbg_req = 1'b1;
      bus.dbg_addr = 8'h10;
      tick();
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", {31'h0, bus.inst_valid}, 32'h0);
      chk("mid_rst_out",   {16'h0, bus.inst_out, bus.inst_pc}, 32'h0);
      chk("mid_rst_dbg",   {23'h0, bus.dbg_ack, bus.dbg_data}, 32'h0);
      chk("mid_rst_addr",  {23'h0, bus.halted, bus.rom_addr}, 32'h0);
      chk("mid_rst_q",     q_inst.size() + q_dbg.size(), 32'h0);
      tick(); tick();
      bus.dbg_req = 1'b0;
      rst_n = 1'b1;
      expect_range(0, 3);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("dropped_ack", {31'h0, bus.dbg_ack}, 32'h0);
         tick();
      end
      bus.inst_ready = 1'b0;
      @(negedge clk);
      chk("post_rst_pc", {23'h0, bus.inst_valid, bus.inst_pc}, {23'h0, 1'b1, 8'h03});
      chk("final_queues", q_inst.size() + q_dbg.size(), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
